// File: rtl/rv32i_mmio_timer_gpio.sv
// Memory-mapped GPIO and prescaled compare timer on the single-cycle CPU data port.
// Reads are combinational; writes commit on the rising clock edge.
module rv32i_mmio_timer_gpio #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Memwrite,
  input  logic [31:0]       Memaddr,
  input  logic [31:0]       MemWdata,
  output logic [31:0]       MemRdata,
  output logic              sel,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam logic [3:0] OffGpioOut = 4'h0;
  localparam logic [3:0] OffGpioIn  = 4'h1;
  localparam logic [3:0] OffCtrl    = 4'h2;
  localparam logic [3:0] OffCount   = 4'h3;
  localparam logic [3:0] OffCmp     = 4'h4;
  localparam logic [3:0] OffStat    = 4'h5;

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic              en_q, en_d;
  logic              autoclr_q, autoclr_d;
  logic              irq_en_q, irq_en_d;
  logic [7:0]        ps_q, ps_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_q, match_d;
  logic              irq_q, irq_d;

  logic [3:0] offset;
  logic       wr_en;
  logic       wr_gpio, wr_ctrl, wr_count, wr_cmp, wr_stat;
  logic       tick, hit;
  logic       unused_addr_lsbs;

  assign offset           = Memaddr[5:2];
  assign sel              = (Memaddr[31:6] == BASE_ADDR[31:6]);
  assign unused_addr_lsbs = ^Memaddr[1:0];

  assign wr_en    = Memwrite & sel;
  assign wr_gpio  = wr_en && (offset == OffGpioOut);
  assign wr_ctrl  = wr_en && (offset == OffCtrl);
  assign wr_count = wr_en && (offset == OffCount);
  assign wr_cmp   = wr_en && (offset == OffCmp);
  assign wr_stat  = wr_en && (offset == OffStat);

  // Tick uses the current en/ps, so a CTRL write only affects later cycles.
  assign tick = en_q && (pcnt_q == ps_q);
  assign hit  = tick && (count_q == cmp_q);

  always_comb begin
    gpio_out_d = wr_gpio ? MemWdata[GPIO_W-1:0] : gpio_out_q;
    en_d       = wr_ctrl ? MemWdata[0] : en_q;
    autoclr_d  = wr_ctrl ? MemWdata[1] : autoclr_q;
    irq_en_d   = wr_ctrl ? MemWdata[2] : irq_en_q;
    ps_d       = wr_ctrl ? MemWdata[15:8] : ps_q;
    cmp_d      = wr_cmp ? MemWdata : cmp_q;

    if (!en_q || wr_count || tick) begin
      pcnt_d = 8'd0;
    end else begin
      pcnt_d = pcnt_q + 8'd1;
    end

    if (wr_count) begin
      count_d = MemWdata;
    end else if (hit && autoclr_q) begin
      count_d = 32'd0;
    end else if (tick) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end

    // A match set on this edge wins over a simultaneous W1C.
    match_d = hit | (match_q & ~(wr_stat & MemWdata[0]));
    irq_d   = match_d & irq_en_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      en_q       <= 1'b0;
      autoclr_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      ps_q       <= 8'd0;
      pcnt_q     <= 8'd0;
      count_q    <= 32'd0;
      cmp_q      <= 32'd0;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      en_q       <= en_d;
      autoclr_q  <= autoclr_d;
      irq_en_q   <= irq_en_d;
      ps_q       <= ps_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    MemRdata = 32'd0;
    if (sel) begin
      case (offset)
        OffGpioOut: MemRdata[GPIO_W-1:0] = gpio_out_q;
        OffGpioIn:  MemRdata[GPIO_W-1:0] = sync2_q;
        OffCtrl: begin
          MemRdata[0]    = en_q;
          MemRdata[1]    = autoclr_q;
          MemRdata[2]    = irq_en_q;
          MemRdata[15:8] = ps_q;
        end
        OffCount:   MemRdata = count_q;
        OffCmp:     MemRdata = cmp_q;
        OffStat:    MemRdata[0] = match_q;
        default:    MemRdata = 32'd0;
      endcase
    end
  end

  assign gpio_out = gpio_out_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_rv32i_mmio_timer_gpio.sv
// Scoreboard bench for the MMIO GPIO/timer block: expectations are queued as
// stimulus is applied and popped when the matching register read is taken.
module tb_rv32i_mmio_timer_gpio;

  localparam logic [31:0] Base = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic        Memwrite;
  logic [31:0] Memaddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;
  logic        sel;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        irq;

  int unsigned checks;
  int unsigned passed;
  logic [31:0] exp_q[$];

  rv32i_mmio_timer_gpio #(
    .BASE_ADDR(Base),
    .GPIO_W   (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Memwrite(Memwrite),
    .Memaddr (Memaddr),
    .MemWdata(MemWdata),
    .MemRdata(MemRdata),
    .sel     (sel),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every bus op starts and ends 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    Memaddr  = Base + {24'd0, off};
    MemWdata = data;
    Memwrite = 1'b1;
    step();
    Memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    Memwrite = 1'b0;
    Memaddr  = addr;
    #1;
    data = MemRdata;
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 6; i++) begin
      rd(Base + 32'(i * 4), got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL reset_reg%0d: got %h expected %h", i, got, e);
      else passed++;
    end
    checks++;
    if (gpio_out !== 8'h00) $display("FAIL reset_gpio_out: got %h expected 00", gpio_out);
    else passed++;
    checks++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
    else passed++;
    rd(Base + 32'h40, got);
    checks++;
    if (sel !== 1'b0) $display("FAIL out_of_window_sel: got %b expected 0", sel);
    else passed++;
    checks++;
    if (got !== 32'd0) $display("FAIL out_of_window_rdata: got %h expected 0", got);
    else passed++;
  endtask

  task automatic test_gpio();
    logic [31:0] got, e;
    wr(8'h00, 32'h0000_00A5);
    checks++;
    if (gpio_out !== 8'hA5) $display("FAIL gpio_out: got %h expected a5", gpio_out);
    else passed++;
    gpio_in = 8'h3C;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h3C);
    step();
    rd(Base + 32'h04, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL gpio_in_1edge: got %h expected %h", got, e);
    else passed++;
    step();
    rd(Base + 32'h04, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL gpio_in_2edge: got %h expected %h", got, e);
    else passed++;
    // Writes to read-only and unmapped offsets must not land anywhere.
    wr(8'h04, 32'hFFFF_FFFF);
    wr(8'h18, 32'hFFFF_FFFF);
    exp_q.push_back(32'h3C);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hA5);
    rd(Base + 32'h04, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL gpio_in_ro: got %h expected %h", got, e);
    else passed++;
    rd(Base + 32'h18, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL unmapped_read: got %h expected %h", got, e);
    else passed++;
    rd(Base + 32'h00, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL gpio_out_kept: got %h expected %h", got, e);
    else passed++;
  endtask

  task automatic test_autoclr();
    logic [31:0] got, e;
    wr(8'h10, 32'd3);
    wr(8'h08, 32'h0000_0007);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) step();
      rd(Base + 32'h0C, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL autoclr_count%0d: got %h expected %h", i, got, e);
      else passed++;
    end
    rd(Base + 32'h14, got);
    checks++;
    if (got !== 32'd1) $display("FAIL autoclr_match: got %h expected 1", got);
    else passed++;
    step();
    checks++;
    if (irq !== 1'b1) $display("FAIL autoclr_irq: got %b expected 1", irq);
    else passed++;
    wr(8'h14, 32'd1);
    rd(Base + 32'h14, got);
    checks++;
    if (got !== 32'd0) $display("FAIL w1c_match: got %h expected 0", got);
    else passed++;
    checks++;
    if (irq !== 1'b0) $display("FAIL w1c_irq: got %b expected 0", irq);
    else passed++;
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd0);
  endtask

  task automatic test_prescale();
    logic [31:0] got, e;
    wr(8'h08, 32'h0000_0201);
    rd(Base + 32'h08, got);
    checks++;
    if (got !== 32'h0000_0201) $display("FAIL ctrl_readback: got %h expected 00000201", got);
    else passed++;
    for (int i = 0; i < 7; i++) exp_q.push_back(32'(i / 3) + ((i % 3 == 0 && i != 0) ? 0 : 0));
    for (int i = 0; i < 7; i++) begin
      if (i != 0) step();
      rd(Base + 32'h0C, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL ps2_count%0d: got %h expected %h", i, got, e);
      else passed++;
    end
    wr(8'h08, 32'd0);
    repeat (4) step();
    rd(Base + 32'h0C, got);
    checks++;
    if (got !== 32'd2) $display("FAIL count_frozen: got %h expected 2", got);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] got, e;
    wr(8'h10, 32'd5);
    wr(8'h0C, 32'hFFFF_FFFF);
    wr(8'h08, 32'h0000_0001);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    step();
    rd(Base + 32'h0C, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL wrap_count: got %h expected %h", got, e);
    else passed++;
    rd(Base + 32'h14, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL wrap_no_match: got %h expected %h", got, e);
    else passed++;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h101);
    wr(8'h0C, 32'h100);
    rd(Base + 32'h0C, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL count_write_wins: got %h expected %h", got, e);
    else passed++;
    step();
    rd(Base + 32'h0C, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL count_after_write: got %h expected %h", got, e);
    else passed++;
  endtask

  task automatic test_w1c_race_and_reset();
    logic [31:0] got;
    wr(8'h0C, 32'd5);
    wr(8'h14, 32'd1);
    rd(Base + 32'h14, got);
    checks++;
    if (got !== 32'd1) $display("FAIL w1c_race_match: got %h expected 1", got);
    else passed++;
    wr(8'h08, 32'h0000_0005);
    checks++;
    if (irq !== 1'b1) $display("FAIL irq_on_irq_en: got %b expected 1", irq);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(Base + 32'h0C, got);
    checks++;
    if (got !== 32'd0) $display("FAIL reset_mid_count: got %h expected 0", got);
    else passed++;
    rd(Base + 32'h14, got);
    checks++;
    if (got !== 32'd0) $display("FAIL reset_mid_match: got %h expected 0", got);
    else passed++;
    checks++;
    if (irq !== 1'b0) $display("FAIL reset_mid_irq: got %b expected 0", irq);
    else passed++;
    checks++;
    if (gpio_out !== 8'h00) $display("FAIL reset_mid_gpio: got %h expected 00", gpio_out);
    else passed++;
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    reset    = 1'b1;
    Memwrite = 1'b0;
    Memaddr  = Base;
    MemWdata = 32'd0;
    gpio_in  = 8'h00;
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_gpio();
    test_autoclr();
    test_prescale();
    test_wrap();
    test_w1c_race_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
